// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg -- shared definitions for the bit-serial subtractor.
//   state_t            : FSM encoding (IDLE / RUN / DONE)
//   SERIAL_SUB_WIDTH   : default operand width
//   cnt_width()        : bit counter width for a given operand width
package serial_sub_pkg;

   localparam int SERIAL_SUB_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A counter must be at least one bit wide, even when only one bit is processed.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/fs_cell.sv
// fs_cell -- one-bit full subtractor, purely combinational.
//   a, b : operand bits (a - b)
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module fs_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// serial_sub -- bit-serial subtractor, d = a - b - bin (mod 2^WIDTH), LSB first.
// One operand set is accepted in IDLE, WIDTH bits are processed in RUN (one
// per clock), and the result is held in DONE until the consumer takes it.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, bin)
//   out_valid/ out_ready: result handshake (d, bout)
//   busy                : high while an operation is in RUN or DONE
//   ovf                 : signed overflow, present only with SERIAL_SUB_OVF_EN
//
// Build option
//   SERIAL_SUB_OVF_EN   : adds the ovf output and its register.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = SERIAL_SUB_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             busy
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int              CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] a_sh, b_sh;   // operands shift right so bit cnt is always at [0]
   logic [WIDTH-1:0] res_q;
   logic [WIDTH:0]   res_cat;
   logic             br_q;
   logic             cell_d, cell_bout;

   fs_cell u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (br_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   // New difference bit enters at the MSB; after WIDTH shifts bit 0 lands at [0].
   // Built as a concatenation so WIDTH=1 needs no special case.
   assign res_cat = {cell_d, res_q};

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt_q == LAST) state_d = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         a_sh  <= '0;
         b_sh  <= '0;
         res_q <= '0;
         br_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  br_q  <= bin;
                  cnt_q <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               br_q  <= cell_bout;
               res_q <= res_cat[WIDTH:1];
               cnt_q <= cnt_q + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign d    = res_q;
   assign bout = br_q;

`ifdef SERIAL_SUB_OVF_EN
   // Overflow is decided on the MSB step: operand signs differ and the result
   // sign differs from the minuend's.
   logic ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_q <= 1'b0;
      else if (state_q == RUN && cnt_q == LAST)
         ovf_q <= (a_sh[0] ^ b_sh[0]) & (cell_d ^ a_sh[0]);
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] d;
   logic         bout;
   logic         busy;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   serial_sub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .bout      (bout),
      .busy      (busy)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] d;
      logic         bout;
      logic         ovf;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer subtraction; a negative result means a borrow out.
   function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin);
      exp_t m;
      int   diff;
      diff   = int'(va) - int'(vb) - int'(vbin);
      m.d    = diff[W-1:0];
      m.bout = (diff < 0);
      m.ovf  = (va[W-1] != vb[W-1]) && (m.d[W-1] != va[W-1]);
      return m;
   endfunction

   // ---------------- monitor ----------------
   int           acc_cyc = 0;
   bit           in_done = 0;
   logic [W-1:0] hold_d;
   logic         hold_b;
   exp_t         e;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_done = 0;
      end else begin
         if (in_valid && in_ready) acc_cyc = cyc + 1;
         if (out_valid) begin
            chk("in_ready_in_done", in_ready, 0);
            chk("busy_in_done", busy, 1);
            if (!in_done) begin
               in_done = 1;
               chk("latency", cyc - acc_cyc, W);
               hold_d = d;
               hold_b = bout;
            end else begin
               chk("hold_d", d, hold_d);
               chk("hold_bout", bout, hold_b);
            end
            if (out_ready) begin
               in_done = 0;
               if (sb.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_result actual=%0h expected=none", d);
               end else begin
                  e = sb.pop_front();
                  chk("d", d, e.d);
                  chk("bout", bout, e.bout);
`ifdef SERIAL_SUB_OVF_EN
                  chk("ovf", ovf, e.ovf);
`endif
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin);
      bit ok = 0;
      a = va; b = vb; bin = vbin; in_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL accept_timeout actual=in_ready_low expected=in_ready_high");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (ok) sb.push_back(model(va, vb, vbin));
   endtask

   task automatic drain(input int stall);
      bit ok = 0;
      for (int i = 0; i < 60; i++) begin
         if (out_valid) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL result_timeout actual=out_valid_low expected=out_valid_high");
         return;
      end
      repeat (stall) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_d", d, 0);
      chk("rst_bout", bout, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // basic subtractions
      issue(8'h05, 8'h03, 1'b0); drain(0);
      issue(8'h03, 8'h05, 1'b0); drain(1);
      issue(8'h00, 8'h00, 1'b1); drain(0);

      // stall in DONE while new operands are presented
      issue(8'h5A, 8'h33, 1'b0);
      drain_wait: for (int i = 0; i < 60; i++) begin
         if (out_valid) break;
         @(posedge clk); #1;
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
         @(posedge clk); #1;
      end
      a = 8'h10; b = 8'h20; bin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("idle_after_ack_in_ready", in_ready, 1);
      chk("idle_after_ack_out_valid", out_valid, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("accept_next_cycle", busy, 1);
      sb.push_back(model(8'h10, 8'h20, 1'b1));
      drain(0);

      // reset in the middle of RUN (bit 4)
      issue(8'h77, 8'h11, 1'b0);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrun_rst_in_ready", in_ready, 1);
      chk("midrun_rst_out_valid", out_valid, 0);
      chk("midrun_rst_busy", busy, 0);
      chk("midrun_rst_d", d, 0);
      chk("midrun_rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
      chk("midrun_rst_ovf", ovf, 0);
`endif
      sb.delete();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      issue(8'hFF, 8'h01, 1'b0); drain(1);

`ifdef SERIAL_SUB_OVF_EN
      issue(8'h80, 8'h01, 1'b0); drain(0);
      issue(8'h05, 8'h03, 1'b0); drain(0);
`endif

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         issue(W'($urandom), W'($urandom), 1'($urandom));
         drain($urandom_range(0, 3));
      end
      issue(8'hFF, 8'hFF, 1'b1); drain(0);
      issue(8'h00, 8'hFF, 1'b0); drain(2);

      repeat (2) @(posedge clk); #1;
      chk("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
